wsg_sound: RTL

Parametrised Namco-style waveform sound generator (WSG) for the arcade cores. It runs N time-multiplexed voices, each with its own phase accumulator, a 4-bit wave select and a 4-bit volume. Voices fetch 4-bit samples from external wave PROMs, and their contributions are summed and saturated into one signed sample per audio period. It sits between the CPU bus decode in the top level and the HDMI audio sample register. It generalises the fixed 3-voice pacman sound path: channel count, rates and output width are parameters, and it adds per-voice mute, saturation with a clip flag and a sample-valid strobe.

---
 rtl/wsg_pkg.sv | 14 +
 rtl/wsg_tick.sv | 15 +
 rtl/wsg_sound.sv | 128 ++++++++++++
 3 files changed

// File: rtl/wsg_pkg.sv
// wsg_pkg: register offsets, sequencer states and sizing helpers for the waveform sound generator.
package wsg_pkg;
  localparam logic [2:0] REG_FREQ0 = 3'd0;
  localparam logic [2:0] REG_FREQ1 = 3'd1;
  localparam logic [2:0] REG_FREQ2 = 3'd2;
  localparam logic [2:0] REG_FREQ3 = 3'd3;
  localparam logic [2:0] REG_FREQ4 = 3'd4;
  localparam logic [2:0] REG_WAVE = 3'd5;
  localparam logic [2:0] REG_VOL = 3'd6;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, ACC, DONE} state_t;
  function automatic int sum_w(input int channels);
    return 8 + $clog2(channels);
  endfunction
endpackage

// File: rtl/wsg_tick.sv
// wsg_tick: free-running divider producing one tick every DIV clocks.
module wsg_tick #(
  parameter int DIV = 1450
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(DIV - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/wsg_sound.sv
// wsg_sound: time-multiplexed wavetable voices mixed and saturated into one signed sample per audio period.
module wsg_sound
  import wsg_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int CLK_HZ = 34800000,
  parameter int SAMPLE_HZ = 24000,
  parameter int ACC_W = 20,
  parameter int IDX_LSB = 13,
  parameter int OUT_W = 10,
  parameter bit LOW_NIB_MASK = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      reg_wr,
  input  logic [$clog2(CHANNELS)+2:0] reg_addr,
  input  logic [3:0]                reg_din,
  input  logic [CHANNELS-1:0]       mute,
  output logic                      rom_rd,
  output logic [8:0]                rom_addr,
  input  logic [3:0]                rom_data,
  output logic signed [OUT_W-1:0]   sample_out,
  output logic                      sample_valid,
  output logic                      clip
);
  localparam int DIV = CLK_HZ / SAMPLE_HZ;
  localparam int AW = $clog2(CHANNELS) + 3;
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam int SUM_W = sum_w(CHANNELS);
  if (DIV < 3 * CHANNELS + 3) begin : g_div_chk
    $error("wsg_sound: CLK_HZ/SAMPLE_HZ too small to sequence all voices");
  end
  state_t state, nxt;
  logic tick;
  logic [CW-1:0] ch;
  logic [19:0] freq [CHANNELS];
  logic [3:0] wave [CHANNELS];
  logic [3:0] vol [CHANNELS];
  logic [ACC_W-1:0] acc [CHANNELS];
  logic [ACC_W-1:0] s_acc, s_freq;
  logic [3:0] s_vol;
  logic signed [SUM_W-1:0] sum, p_ext;
  logic signed [4:0] s;
  logic signed [7:0] p8;
  logic [19:0] f_raw, f_eff;
  logic [AW-1:0] wv;
  logic [CW-1:0] wr_v;
  logic wr_ok;
  logic signed [OUT_W-1:0] sat;
  logic sat_clip;
  wsg_tick #(.DIV(DIV)) u_tick (.clk(clk), .reset_n(reset_n), .tick(tick));
  assign wv = reg_addr >> 3;
  assign wr_v = wv[CW-1:0];
  assign wr_ok = reg_wr && wv < AW'(CHANNELS) && reg_addr[2:0] != 3'd7;
  // Upper voices ignore their lowest frequency nibble, as on the original board.
  assign f_raw = freq[ch];
  assign f_eff = (LOW_NIB_MASK && ch != '0) ? {f_raw[19:4], 4'h0} : f_raw;
  assign s = $signed({1'b0, rom_data}) - 5'sd7;
  assign p8 = $signed({4'b0, s_vol}) * $signed({{3{s[4]}}, s});
  assign p_ext = SUM_W'(p8);
  if (SUM_W <= OUT_W) begin : g_ext
    assign sat = OUT_W'(sum);
    assign sat_clip = 1'b0;
  end else begin : g_clamp
    localparam logic signed [SUM_W-1:0] HI = SUM_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] LO = ~HI;
    assign sat_clip = sum > HI || sum < LO;
    assign sat = sum > HI ? HI[OUT_W-1:0] : sum < LO ? LO[OUT_W-1:0] : sum[OUT_W-1:0];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = tick ? FETCH : IDLE;
      FETCH:   nxt = WAIT;
      WAIT:    nxt = ACC;
      ACC:     nxt = ch == CW'(CHANNELS - 1) ? DONE : FETCH;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        freq[i] <= '0;
        wave[i] <= '0;
        vol[i] <= '0;
        acc[i] <= '0;
      end
      ch <= '0;
      s_acc <= '0;
      s_freq <= '0;
      s_vol <= '0;
      sum <= '0;
      rom_rd <= 1'b0;
      rom_addr <= '0;
      sample_out <= '0;
      sample_valid <= 1'b0;
      clip <= 1'b0;
    end else begin
      if (wr_ok) begin
        if (reg_addr[2:0] == REG_WAVE) wave[wr_v] <= reg_din;
        else if (reg_addr[2:0] == REG_VOL) vol[wr_v] <= reg_din;
        else freq[wr_v][{reg_addr[2:0], 2'b00} +: 4] <= reg_din;
      end
      rom_rd <= state == FETCH;
      sample_valid <= state == DONE;
      clip <= state == DONE && sat_clip;
      if (state == IDLE && tick) ch <= '0;
      if (state == FETCH) begin
        s_acc <= acc[ch];
        s_freq <= ACC_W'(f_eff);
        s_vol <= vol[ch];
        rom_addr <= {wave[ch], acc[ch][IDX_LSB +: 5]};
      end
      if (state == ACC) begin
        sum <= mute[ch] ? sum : sum + p_ext;
        acc[ch] <= s_acc + s_freq;
        if (ch != CW'(CHANNELS - 1)) ch <= ch + 1'b1;
      end
      if (state == DONE) begin
        sample_out <= sat;
        sum <= '0;
      end
    end
endmodule
